// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//
// Shared types for the elastic pipeline-stage register and the stage wrappers
// that sit on top of it.
//
//   pipeline_control_t : control bundle carried alongside each pipeline entry.
//   id_ex_data_t       : example stage data payload (pc, rs1, rs2, imm). Stage
//                        wrappers cast their own struct onto the flat in_data
//                        bus of pipe_stage_elastic.
//   pipe_state_t       : occupancy state of one stage register.
//   state_occupancy()  : maps a pipe_state_t onto the 0..2 entry count.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    // Control bits travelling with an instruction. A bubble carries all-zero
    // control, so it can never write the register file or memory.
    typedef struct packed {
        logic       WB_reg_write;
        logic       WB_mem_to_reg;
        logic       M_branch;
        logic       M_mem_read;
        logic       M_mem_write;
        logic [1:0] EX_ALU_Op;
        logic       EX_ALU_Src;
    } pipeline_control_t;

    localparam int CTRL_W_DEFAULT = $bits(pipeline_control_t);

    // Typical ID/EX data payload; four 32-bit words.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
    } id_ex_data_t;

    localparam int DATA_W_DEFAULT = $bits(id_ex_data_t);

    // EMPTY: nothing held. BUSY: main slot holds the head entry.
    // FULL : main and skid slots both hold entries (skid is the younger one).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage : pipeline_pkg

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Parametrised elastic register placed between two pipeline stages. It holds
// up to two entries (main + skid) so that in_ready can be a flop, which breaks
// the combinational ready chain that would otherwise run back through every
// stage of the pipeline. With SKID_EN=0 it degrades to a single-entry register
// whose in_ready is combinational.
//
// Handshake: an entry moves on a rising clock edge when valid and ready are
// both high in that cycle (in_fire = in_valid & in_ready, out_fire = out_valid
// & out_ready). A producer holding valid high must keep its payload stable
// until it sees ready; once out_valid is high, out_data/out_ctrl stay stable
// until out_fire.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous squash of all held entries (level)
//   in_valid   in   upstream presents an entry
//   in_ready   out  stage accepts an entry this cycle
//   in_data    in   [DATA_W] data payload
//   in_ctrl    in   [CTRL_W] control payload
//   out_valid  out  entry presented downstream
//   out_ready  in   downstream accepts the entry
//   out_data   out  [DATA_W] data of head entry
//   out_ctrl   out  [CTRL_W] control of head entry, zero when out_valid=0
//   occupancy  out  [2] number of held entries (0..2)
//   dbg_state  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module pipe_stage_elastic
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CTRL_W  = CTRL_W_DEFAULT,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output pipe_state_t       dbg_state
);

    // One storage slot. Main and skid are two copies of the same slot logic.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } slot_t;

    // Emptying a slot drops valid and control; data is left alone because it
    // is meaningless without valid and not clearing it saves enables.
    function automatic slot_t vacate(input slot_t s);
        slot_t r;
        r       = s;
        r.valid = 1'b0;
        r.ctrl  = '0;
        return r;
    endfunction

    pipe_state_t state_q, state_d;
    slot_t       main_q, main_d;
    slot_t       skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    slot_t       in_slot;
    logic        in_fire;
    logic        out_fire;

    assign in_slot = '{valid: 1'b1, ctrl: in_ctrl, data: in_data};

    // With the skid slot, ready comes straight from a flop. Without it, a
    // full stage can still accept when the head is leaving this same cycle.
    assign in_ready = SKID_EN ? in_ready_q : (!main_q.valid || out_ready);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_q.valid && out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Squash everything; an entry arriving this cycle is dropped and
            // an entry leaving this cycle was already sampled downstream.
            state_d = EMPTY;
            main_d  = vacate(main_q);
            skid_d  = vacate(skid_q);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_slot;
                    end
                end

                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_slot;
                    end else if (in_fire) begin
                        // Head is stalled: park the newcomer behind it. Only
                        // reachable with SKID_EN=1, since otherwise in_ready
                        // is low while the head is stalled.
                        state_d = FULL;
                        skid_d  = in_slot;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = vacate(main_q);
                    end
                end

                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                        skid_d  = vacate(skid_q);
                    end
                end

                default: begin
                    state_d = EMPTY;
                    main_d  = vacate(main_q);
                    skid_d  = vacate(skid_q);
                end
            endcase
        end

        // Registered ready: accept next cycle unless both slots will be used.
        in_ready_d = (state_d != FULL);
    end

    // -------------------------------------------------------------------------
    // State and slot registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = main_q.valid;
    assign out_data  = main_q.data;
    // Gate control with valid so a bubble can never assert a write enable.
    assign out_ctrl  = main_q.valid ? main_q.ctrl : '0;
    assign occupancy = state_occupancy(state_q);
    assign dbg_state = state_q;

endmodule : pipe_stage_elastic

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Two instances share the same stimulus: u_skid (SKID_EN=1) and u_noskid
// (SKID_EN=0). mdl_skid selects which instance the reference model follows.
// The model is a plain FIFO of entries with a capacity of 2 (skid) or 1
// (no skid); flush empties it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;
    import pipeline_pkg::*;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int NV = 20;

    // ---------------- clock / reset / shared stimulus ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;

    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [DW-1:0] s_out_data, n_out_data;
    logic [CW-1:0] s_out_ctrl, n_out_ctrl;
    logic [1:0]    s_occ, n_occ;
    pipe_state_t   s_state, n_state;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) u_skid (
        .clock(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occ), .dbg_state(s_state)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0)) u_noskid (
        .clock(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .occupancy(n_occ), .dbg_state(n_state)
    );

    bit mdl_skid = 1'b1;

    logic          act_ir, act_ov;
    logic [DW-1:0] act_od;
    logic [CW-1:0] act_oc;
    logic [1:0]    act_occ;
    pipe_state_t   act_state;

    assign act_ir    = mdl_skid ? s_in_ready  : n_in_ready;
    assign act_ov    = mdl_skid ? s_out_valid : n_out_valid;
    assign act_od    = mdl_skid ? s_out_data  : n_out_data;
    assign act_oc    = mdl_skid ? s_out_ctrl  : n_out_ctrl;
    assign act_occ   = mdl_skid ? s_occ       : n_occ;
    assign act_state = mdl_skid ? s_state     : n_state;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } ent_t;

    ent_t exp_q[$];
    bit   m_in_fire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (mdl_skid) return exp_q.size() < 2;
        return (exp_q.size() == 0) || (out_ready == 1'b1);
    endfunction

    function automatic pipe_state_t model_state();
        if (exp_q.size() == 0) return EMPTY;
        if (exp_q.size() == 1) return BUSY;
        return FULL;
    endfunction

    // Apply the current inputs to the model as the clock edge would.
    task automatic model_edge();
        bit out_fire_m;
        m_in_fire  = (in_valid == 1'b1) && model_ready();
        out_fire_m = (exp_q.size() > 0) && (out_ready == 1'b1);
        if (flush == 1'b1) begin
            exp_q.delete();
        end else begin
            if (out_fire_m) void'(exp_q.pop_front());
            if (m_in_fire) exp_q.push_back('{data: in_data, ctrl: in_ctrl});
        end
    endtask

    task automatic check_model(input string tag);
        bit            ev;
        logic [CW-1:0] ec;
        ev = exp_q.size() > 0;
        ec = '0;
        if (ev) ec = exp_q[0].ctrl;
        check({tag, ".out_valid"}, 32'(act_ov), 32'(ev));
        check({tag, ".out_ctrl"}, 32'(act_oc), 32'(ec));
        check({tag, ".occupancy"}, 32'(act_occ), 32'(exp_q.size()));
        check({tag, ".in_ready"}, 32'(act_ir), 32'(model_ready()));
        check({tag, ".state"}, 32'(act_state), 32'(model_state()));
        if (ev) check({tag, ".out_data"}, 32'(act_od), 32'(exp_q[0].data));
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".in_ready_pre"}, 32'(act_ir), 32'(model_ready()));
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".s_out_valid"}, 32'(s_out_valid), 32'h0);
        check({tag, ".s_out_data"}, 32'(s_out_data), 32'h0);
        check({tag, ".s_out_ctrl"}, 32'(s_out_ctrl), 32'h0);
        check({tag, ".s_occupancy"}, 32'(s_occ), 32'h0);
        check({tag, ".s_in_ready"}, 32'(s_in_ready), 32'h1);
        check({tag, ".n_out_valid"}, 32'(n_out_valid), 32'h0);
        check({tag, ".n_out_data"}, 32'(n_out_data), 32'h0);
        check({tag, ".n_out_ctrl"}, 32'(n_out_ctrl), 32'h0);
        check({tag, ".n_occupancy"}, 32'(n_occ), 32'h0);
        check({tag, ".n_in_ready"}, 32'(n_in_ready), 32'h1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic [CW-1:0] ic;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic [1:0]    eocc;
        logic          eir;
    } vec_t;

    vec_t tbl[NV];

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                                input logic ordy, input logic fl, input logic ev,
                                input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                                input logic [1:0] eocc, input logic eir);
        vec_t v;
        v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eocc = eocc; v.eir = eir;
        return v;
    endfunction

    task automatic fill_table();
        // streaming at full rate: one cycle latency, occupancy stays 1
        tbl[0]  = mk(1'b1, 16'h11, 8'h01, 1'b1, 1'b0, 1'b1, 16'h11, 8'h01, 2'd1, 1'b1);
        tbl[1]  = mk(1'b1, 16'h12, 8'h02, 1'b1, 1'b0, 1'b1, 16'h12, 8'h02, 2'd1, 1'b1);
        tbl[2]  = mk(1'b1, 16'h13, 8'h03, 1'b1, 1'b0, 1'b1, 16'h13, 8'h03, 2'd1, 1'b1);
        tbl[3]  = mk(1'b1, 16'h14, 8'h04, 1'b1, 1'b0, 1'b1, 16'h14, 8'h04, 2'd1, 1'b1);
        tbl[4]  = mk(1'b1, 16'h15, 8'h05, 1'b1, 1'b0, 1'b1, 16'h15, 8'h05, 2'd1, 1'b1);
        tbl[5]  = mk(1'b0, 16'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        // A then B into a stalled stage, then drain in order
        tbl[6]  = mk(1'b1, 16'h0A, 8'h0A, 1'b0, 1'b0, 1'b1, 16'h0A, 8'h0A, 2'd1, 1'b1);
        tbl[7]  = mk(1'b1, 16'h0B, 8'h0B, 1'b0, 1'b0, 1'b1, 16'h0A, 8'h0A, 2'd2, 1'b0);
        tbl[8]  = mk(1'b0, 16'h00, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0A, 8'h0A, 2'd2, 1'b0);
        tbl[9]  = mk(1'b0, 16'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0B, 8'h0B, 2'd1, 1'b1);
        tbl[10] = mk(1'b0, 16'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        // fill with ctrl=FF, then flush while 0x0C is offered
        tbl[11] = mk(1'b1, 16'h21, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h21, 8'hFF, 2'd1, 1'b1);
        tbl[12] = mk(1'b1, 16'h22, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h21, 8'hFF, 2'd2, 1'b0);
        tbl[13] = mk(1'b1, 16'h0C, 8'hFF, 1'b0, 1'b1, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        tbl[14] = mk(1'b0, 16'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        // idle with ctrl=FF on the input: bubbles carry no control
        tbl[15] = mk(1'b0, 16'h33, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        tbl[16] = mk(1'b0, 16'h33, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        // flush with a simultaneous out_fire and in_fire: incoming entry dropped
        tbl[17] = mk(1'b1, 16'h41, 8'h11, 1'b0, 1'b0, 1'b1, 16'h41, 8'h11, 2'd1, 1'b1);
        tbl[18] = mk(1'b1, 16'h42, 8'h22, 1'b1, 1'b1, 1'b0, 16'h00, 8'h00, 2'd0, 1'b1);
        tbl[19] = mk(1'b1, 16'h43, 8'h33, 1'b1, 1'b0, 1'b1, 16'h43, 8'h33, 2'd1, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        #3;
        check_reset_outputs("async_reset_t0");
        fill_table();

        // Directed table on the skid instance
        do_reset();
        mdl_skid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            in_ctrl   = tbl[i].ic;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d.out_valid", i), 32'(s_out_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d.out_ctrl", i), 32'(s_out_ctrl), 32'(tbl[i].ec));
            check($sformatf("tbl%0d.occupancy", i), 32'(s_occ), 32'(tbl[i].eocc));
            check($sformatf("tbl%0d.in_ready", i), 32'(s_in_ready), 32'(tbl[i].eir));
            if (tbl[i].ev) check($sformatf("tbl%0d.out_data", i), 32'(s_out_data), 32'(tbl[i].ed));
        end
        flush = 1'b0;

        // Asynchronous reset while FULL, asserted mid-cycle
        do_reset();
        mdl_skid  = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h61;
        in_ctrl   = 8'hFF;
        out_ready = 1'b0;
        cycle("fill1");
        in_data = 16'h62;
        cycle("fill2");
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(s_out_valid), 32'h0);
        check("midrst.out_data", 32'(s_out_data), 32'h0);
        check("midrst.out_ctrl", 32'(s_out_ctrl), 32'h0);
        check("midrst.occupancy", 32'(s_occ), 32'h0);
        check("midrst.in_ready", 32'(s_in_ready), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;

        // No-skid instance: toggling out_ready under a continuous stream
        do_reset();
        mdl_skid = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h51;
        in_ctrl  = 8'h51;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            cycle("ns_toggle");
            if (m_in_fire) begin
                in_data = in_data + 1'b1;
                in_ctrl = in_ctrl + 1'b1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle("ns_drain");
        cycle("ns_drain");

        // Randomised traffic against the model, both configurations
        for (int m = 0; m < 2; m++) begin
            do_reset();
            mdl_skid = (m == 0);
            repeat (300) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                flush     = ($urandom_range(0, 24) == 0);
                in_data   = DW'($urandom);
                in_ctrl   = CW'($urandom);
                cycle(m == 0 ? "rand_skid" : "rand_noskid");
            end
            flush = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_elastic
